// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating counters
// Optional BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predictor #(
  parameter int XLEN       = 64,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_if,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
`endif
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic                validQ  [ENTRIES];
  logic [TAG_BITS-1:0] tagQ    [ENTRIES];
  logic [XLEN-1:0]     targetQ [ENTRIES];
  logic [1:0]          ctrQ    [ENTRIES];

  logic [INDEX_BITS-1:0] lookupIdx;
  logic [INDEX_BITS-1:0] updIdx;
  logic [TAG_BITS-1:0]   lookupTag;
  logic [TAG_BITS-1:0]   updTag;
  logic                  lookupHit;
  logic                  updHit;

  assign lookupIdx = pc_if[INDEX_BITS+1:2];
  assign lookupTag = pc_if[TAG_HI:TAG_LO];
  assign updIdx    = upd_pc[INDEX_BITS+1:2];
  assign updTag    = upd_pc[TAG_HI:TAG_LO];

  assign lookupHit = validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag);
  assign updHit    = validQ[updIdx] && (tagQ[updIdx] == updTag);

  // Gated by reset so the stale table never leaks out while reset is held.
  assign predict_taken  = !reset && lookupHit && ctrQ[lookupIdx][1];
  assign predict_target = predict_taken ? targetQ[lookupIdx] : pc_if + XLEN'(4);

  assign mispredict = upd_valid && !reset &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= '0;
        ctrQ[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (updHit) begin
        if (upd_taken) begin
          if (ctrQ[updIdx] != 2'b11) ctrQ[updIdx] <= ctrQ[updIdx] + 2'd1;
          targetQ[updIdx] <= upd_target;
        end else if (ctrQ[updIdx] != 2'b00) begin
          ctrQ[updIdx] <= ctrQ[updIdx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Taken miss claims the slot, evicting whatever lived there.
        validQ[updIdx]  <= 1'b1;
        tagQ[updIdx]    <= updTag;
        targetQ[updIdx] <= upd_target;
        ctrQ[updIdx]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (upd_valid && (branch_count != 32'hFFFF_FFFF))
        branch_count <= branch_count + 32'd1;
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - vector table and scoreboard bench for branch_predictor
// Define BP_STATS_EN to also exercise the statistics counters.
module tb_branch_predictor;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] pcIf;
  logic            predictTaken;
  logic [XLEN-1:0] predictTarget;
  logic            updValid;
  logic [XLEN-1:0] updPc;
  logic            updTaken;
  logic [XLEN-1:0] updTarget;
  logic            updPredTaken;
  logic [XLEN-1:0] updPredTarget;
  logic            mispredict;
  logic [XLEN-1:0] redirectPc;
`ifdef BP_STATS_EN
  logic [31:0]     branchCount;
  logic [31:0]     mispredictCount;
`endif

  branch_predictor #(.XLEN(XLEN), .INDEX_BITS(4), .TAG_BITS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_if          (pcIf),
    .predict_taken  (predictTaken),
    .predict_target (predictTarget),
    .upd_valid      (updValid),
    .upd_pc         (updPc),
    .upd_taken      (updTaken),
    .upd_target     (updTarget),
    .upd_pred_taken (updPredTaken),
    .upd_pred_target(updPredTarget),
    .mispredict     (mispredict),
    .redirect_pc    (redirectPc)
`ifdef BP_STATS_EN
    ,
    .branch_count   (branchCount),
    .mispredict_count(mispredictCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic [XLEN-1:0] pc;
    logic            uv;
    logic [XLEN-1:0] upc;
    logic            ut;
    logic [XLEN-1:0] utgt;
    logic            upt;
    logic [XLEN-1:0] uptgt;
    logic            ePt;
    logic [XLEN-1:0] ePtgt;
    logic            eMis;
    logic [XLEN-1:0] eRed;
  } vecT;

  typedef struct {
    int              id;
    logic            pt;
    logic [XLEN-1:0] ptgt;
    logic            mis;
    logic [XLEN-1:0] red;
  } expT;

  vecT vecs[$];
  expT expQ[$];
  int  errors = 0;
  int  checks = 0;

  function automatic vecT mkVec(logic rst, logic [XLEN-1:0] pc, logic uv, logic [XLEN-1:0] upc,
                                logic ut, logic [XLEN-1:0] utgt, logic upt, logic [XLEN-1:0] uptgt,
                                logic ePt, logic [XLEN-1:0] ePtgt, logic eMis, logic [XLEN-1:0] eRed);
    vecT v;
    v.rst = rst; v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.ePt = ePt; v.ePtgt = ePtgt; v.eMis = eMis; v.eRed = eRed;
    return v;
  endfunction

  task automatic check(input string name, input int id, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic drive(input vecT v);
    reset         = v.rst;
    pcIf          = v.pc;
    updValid      = v.uv;
    updPc         = v.upc;
    updTaken      = v.ut;
    updTarget     = v.utgt;
    updPredTaken  = v.upt;
    updPredTarget = v.uptgt;
  endtask

  localparam logic [XLEN-1:0] A  = 64'h1000;
  localparam logic [XLEN-1:0] E  = 64'h0F00;
  localparam logic [XLEN-1:0] B  = 64'h2000;
  localparam logic [XLEN-1:0] AL = 64'h1000 + (64'd1 << 14);
  localparam logic [XLEN-1:0] T3 = 64'h3000;
  localparam logic [XLEN-1:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    // rst, pc, uv, upc, ut, utgt, upt, uptgt, ePt, ePtgt, eMis, eRed
    vecs.push_back(mkVec(1, A, 1, A, 1, E, 0, 0, 0, A+4, 0, 0));      // reset beats update
    vecs.push_back(mkVec(0, A, 0, 0, 0, 0, 0, 0, 0, A+4, 0, 0));      // table still empty
    vecs.push_back(mkVec(0, A, 1, A, 1, E, 0, 0, 0, A+4, 1, E));      // allocate, ctr=10
    vecs.push_back(mkVec(0, A, 1, A, 1, E, 1, E, 1, E, 0, 0));        // ctr 11
    vecs.push_back(mkVec(0, A, 1, A, 1, E, 1, E, 1, E, 0, 0));        // ctr stays 11
    vecs.push_back(mkVec(0, A, 1, A, 0, 0, 1, E, 1, E, 1, A+4));      // ctr 10
    vecs.push_back(mkVec(0, A, 1, A, 0, 0, 1, E, 1, E, 1, A+4));      // ctr 01
    vecs.push_back(mkVec(0, A, 1, A, 0, 0, 0, 0, 0, A+4, 0, 0));      // ctr 00
    vecs.push_back(mkVec(0, A, 1, A, 0, 0, 0, 0, 0, A+4, 0, 0));      // ctr saturates 00
    vecs.push_back(mkVec(0, A, 1, A, 1, E, 0, 0, 0, A+4, 1, E));      // ctr 01
    vecs.push_back(mkVec(0, A, 0, 0, 0, 0, 0, 0, 0, A+4, 0, 0));      // 01 predicts NT
    vecs.push_back(mkVec(0, B, 1, B, 0, 0, 1, 64'h2008, 0, B+4, 1, B+4));
    vecs.push_back(mkVec(0, B, 1, B, 0, 0, 0, 0, 0, B+4, 0, 0));
    vecs.push_back(mkVec(0, B, 0, 0, 0, 0, 0, 0, 0, B+4, 0, 0));      // no allocation on NT miss
    vecs.push_back(mkVec(0, A, 1, A, 1, E, 1, 64'h0F10, 0, A+4, 1, E)); // wrong target, ctr 10
    vecs.push_back(mkVec(0, A, 0, 0, 0, 0, 0, 0, 1, E, 0, 0));
    vecs.push_back(mkVec(0, A, 1, AL, 1, T3, 0, 0, 1, E, 1, T3));     // alias, lookup pre-update
    vecs.push_back(mkVec(0, AL, 0, 0, 0, 0, 0, 0, 1, T3, 0, 0));
    vecs.push_back(mkVec(0, A, 0, 0, 0, 0, 0, 0, 1, T3, 0, 0));
    vecs.push_back(mkVec(0, A, 0, A, 0, 0, 1, E, 1, T3, 0, 0));       // upd_valid=0 ignored
    vecs.push_back(mkVec(0, A, 0, 0, 0, 0, 0, 0, 1, T3, 0, 0));
    vecs.push_back(mkVec(0, TOP, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0));  // pc+4 wraps
    vecs.push_back(mkVec(1, A, 1, A, 1, E, 0, 0, 0, A+4, 0, 0));      // reset mid-run
    vecs.push_back(mkVec(0, AL, 0, 0, 0, 0, 0, 0, 0, AL+4, 0, 0));
    vecs.push_back(mkVec(0, A, 0, 0, 0, 0, 0, 0, 0, A+4, 0, 0));

    drive(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      expT e;
      #1;
      drive(vecs[i]);
      e.id = i; e.pt = vecs[i].ePt; e.ptgt = vecs[i].ePtgt; e.mis = vecs[i].eMis; e.red = vecs[i].eRed;
      expQ.push_back(e);
      @(negedge clk);
      e = expQ.pop_front();
      check("predict_taken", e.id, XLEN'(predictTaken), XLEN'(e.pt));
      check("predict_target", e.id, predictTarget, e.ptgt);
      check("mispredict", e.id, XLEN'(mispredict), XLEN'(e.mis));
      if (e.mis) check("redirect_pc", e.id, redirectPc, e.red);
      @(posedge clk);
    end

`ifdef BP_STATS_EN
    #1;
    drive(mkVec(1, A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("branch_count_reset", 0, XLEN'(branchCount), 0);
    check("mispredict_count_reset", 0, XLEN'(mispredictCount), 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      updValid = 1'b1; updPc = 64'h7000; updTaken = 1'b0; updTarget = 0;
      updPredTaken = (k == 1 || k == 3); updPredTarget = 0;
    end
    @(posedge clk); #1;
    updValid = 1'b0;
    @(negedge clk);
    check("branch_count", 0, XLEN'(branchCount), 5);
    check("mispredict_count", 0, XLEN'(mispredictCount), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("branch_count_clear", 0, XLEN'(branchCount), 0);
    check("mispredict_count_clear", 0, XLEN'(mispredictCount), 0);
`endif

    check("scoreboard_drained", 0, XLEN'(expQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
